// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master SRAM-like bus arbiter with in-order response routing
//
// Purpose:
//   Shares one downstream SRAM-like port between an instruction master and a
//   data master.  Address phases are arbitrated and locked until accepted.
//   The master ID of every accepted transaction goes into an ID FIFO so that
//   in-order data_ok/rdata responses are steered back to the right master.
//
// Parameters:
//   DEPTH            maximum outstanding transactions (power of two, 2..16)
//
// Optional feature macro:
//   ARB_ROUND_ROBIN_EN  when defined, ties alternate using a last_gnt register;
//                       when undefined, the data master always wins a tie.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   inst_sram_req/wr/size/wstrb/addr/wdata   instruction master request
//   inst_sram_addr_ok/data_ok/rdata          instruction master response
//   data_sram_req/wr/size/wstrb/addr/wdata   data master request
//   data_sram_addr_ok/data_ok/rdata          data master response
//   mem_req/wr/size/wstrb/addr/wdata         shared downstream request
//   mem_addr_ok/data_ok/rdata                downstream response
//   outstanding_cnt                          accepted transactions awaiting data_ok

module sram_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     inst_sram_req,
    input  logic                     inst_sram_wr,
    input  logic [1:0]               inst_sram_size,
    input  logic [3:0]               inst_sram_wstrb,
    input  logic [31:0]              inst_sram_addr,
    input  logic [31:0]              inst_sram_wdata,
    output logic                     inst_sram_addr_ok,
    output logic                     inst_sram_data_ok,
    output logic [31:0]              inst_sram_rdata,

    input  logic                     data_sram_req,
    input  logic                     data_sram_wr,
    input  logic [1:0]               data_sram_size,
    input  logic [3:0]               data_sram_wstrb,
    input  logic [31:0]              data_sram_addr,
    input  logic [31:0]              data_sram_wdata,
    output logic                     data_sram_addr_ok,
    output logic                     data_sram_data_ok,
    output logic [31:0]              data_sram_rdata,

    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,

    output logic [$clog2(DEPTH):0]   outstanding_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    owner_t             owner;
    owner_t             owner_next;

    // sel_data: 1 selects the data master, 0 the instruction master.
    logic               sel_data;
    logic               sel_req;
    logic               tie_to_data;

    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               head_data;

    // One bit per FIFO entry: 1 = data master, 0 = instruction master.
    logic [DEPTH-1:0]   id_mem;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data master was granted last; resets to the instruction master so
    // the first tie goes to the data master.
    logic               last_gnt_data;

    always_comb begin
        tie_to_data = ~last_gnt_data;
    end
`else
    always_comb begin
        tie_to_data = 1'b1;
    end
`endif

    // Master selection: a locked owner always keeps the port; otherwise the
    // single requester wins, and a tie falls to tie_to_data.
    always_comb begin
        sel_data = 1'b0;
        case (owner)
            OWN_INST: sel_data = 1'b0;
            OWN_DATA: sel_data = 1'b1;
            default: begin
                if (inst_sram_req && data_sram_req) begin
                    sel_data = tie_to_data;
                end else begin
                    sel_data = data_sram_req;
                end
            end
        endcase
    end

    assign sel_req   = sel_data ? data_sram_req : inst_sram_req;

    // Full is judged on the registered count only, so a pop in the same cycle
    // does not let a new address through until the following cycle.
    assign fifo_full = (count == CNT_W'(DEPTH));

    assign mem_req   = sel_req & ~fifo_full;
    assign mem_wr    = sel_data ? data_sram_wr    : inst_sram_wr;
    assign mem_size  = sel_data ? data_sram_size  : inst_sram_size;
    assign mem_wstrb = sel_data ? data_sram_wstrb : inst_sram_wstrb;
    assign mem_addr  = sel_data ? data_sram_addr  : inst_sram_addr;
    assign mem_wdata = sel_data ? data_sram_wdata : inst_sram_wdata;

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & (count != '0);

    assign inst_sram_addr_ok = push & ~sel_data;
    assign data_sram_addr_ok = push &  sel_data;

    // Responses return strictly in order, so the FIFO head names the owner.
    assign head_data         = id_mem[rd_ptr];
    assign inst_sram_data_ok = pop & ~head_data;
    assign data_sram_data_ok = pop &  head_data;

    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    assign outstanding_cnt   = count;

    // Owner lock: a presented but unaccepted request pins the port to the
    // selected master; acceptance releases it for fresh arbitration.
    always_comb begin
        owner_next = owner;
        if (mem_req && !mem_addr_ok) begin
            owner_next = sel_data ? OWN_DATA : OWN_INST;
        end else if (push) begin
            owner_next = OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_next;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_data <= 1'b0;
        end else if (push) begin
            last_gnt_data <= sel_data;
        end
    end
`endif

    // ID storage needs no reset: entries are only read when count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard testbench for sram_arbiter

module tb_sram_arbiter;

    localparam int DEPTH = 4;
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    logic        clk;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [$clog2(DEPTH):0] outstanding_cnt;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sram_arbiter #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata),
        .outstanding_cnt   (outstanding_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
        data_sram_addr = 0; data_sram_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Advance to just after the next rising edge, ready to drive inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== 0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", outstanding_cnt);
        end
        n_checks++;
        if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok, mem_req} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b want 00000",
                     {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok, mem_req});
        end
    endtask

    task automatic test_priority();
        do_reset();
        inst_sram_req = 1; inst_sram_addr = 32'h1000;
        data_sram_req = 1; data_sram_addr = 32'h2000;
        mem_addr_ok = 1;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h2000 || data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_first: addr %h d_ok %b i_ok %b want 2000 1 0", mem_addr, data_sram_addr_ok, inst_sram_addr_ok);
        end
        step();
        data_sram_req = 0;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h1000 || inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_second: addr %h i_ok %b d_ok %b want 1000 1 0", mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
        end
        step();
        inst_sram_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== 2) begin
            n_fail++; $display("FAIL prio_cnt: got %0d want 2", outstanding_cnt);
        end
    endtask

    task automatic test_lock();
        do_reset();
        inst_sram_req = 1; inst_sram_addr = 32'h1100; mem_addr_ok = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_sram_req = 1; data_sram_addr = 32'h2200;
            end
            @(negedge clk);
            n_checks++;
            if (mem_addr !== 32'h1100 || mem_req !== 1'b1 || inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_hold c%0d: addr %h req %b i_ok %b d_ok %b want 1100 1 0 0",
                         c, mem_addr, mem_req, inst_sram_addr_ok, data_sram_addr_ok);
            end
            step();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h1100 || inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_accept: addr %h i_ok %b d_ok %b want 1100 1 0", mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
        end
        step();
        inst_sram_req = 0;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h2200 || data_sram_addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_release: addr %h d_ok %b want 2200 1", mem_addr, data_sram_addr_ok);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        inst_sram_req = 1; mem_addr_ok = 1;
        for (int k = 0; k < DEPTH; k++) begin
            inst_sram_addr = 32'h3000 + 32'(k * 4);
            @(negedge clk);
            n_checks++;
            if (inst_sram_addr_ok !== 1'b1) begin
                n_fail++; $display("FAIL full_fill%0d: i_ok %b want 1", k, inst_sram_addr_ok);
            end
            sb.push_back('{id: ID_INST, rdata: 32'h5000 + 32'(k)});
            step();
        end
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== DEPTH || mem_req !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL full_block: cnt %0d req %b i_ok %b want %0d 0 0", outstanding_cnt, mem_req, inst_sram_addr_ok, DEPTH);
        end
        step();
        mem_data_ok = 1; mem_rdata = 32'h5000;
        @(negedge clk);
        begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0 || inst_sram_rdata !== e.rdata || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL full_pop: i_dok %b d_dok %b rdata %h req %b want 1 0 %h 0",
                         inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, mem_req, e.rdata);
            end
        end
        step();
        mem_data_ok = 0;
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== DEPTH - 1 || mem_req !== 1'b1 || inst_sram_addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_resume: cnt %0d req %b i_ok %b want %0d 1 1", outstanding_cnt, mem_req, inst_sram_addr_ok, DEPTH - 1);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_in_order();
        logic [31:0] rd_vals [3];
        rd_vals[0] = 32'hA; rd_vals[1] = 32'hB; rd_vals[2] = 32'hC;
        do_reset();
        mem_addr_ok = 1;
        for (int k = 0; k < 3; k++) begin
            logic is_data;
            is_data = (k == 1);
            inst_sram_req = !is_data; inst_sram_addr = 32'h10 + 32'(k * 16);
            data_sram_req = is_data;  data_sram_addr = 32'h20; data_sram_wr = 1;
            data_sram_wstrb = 4'hF;   data_sram_wdata = 32'hCAFE_0001;
            @(negedge clk);
            n_checks++;
            if ({data_sram_addr_ok, inst_sram_addr_ok} !== {is_data, !is_data} || mem_wr !== is_data) begin
                n_fail++;
                $display("FAIL order_issue%0d: d_ok %b i_ok %b wr %b want %b %b %b",
                         k, data_sram_addr_ok, inst_sram_addr_ok, mem_wr, is_data, !is_data, is_data);
            end
            if (is_data) begin
                n_checks++;
                if (mem_wdata !== 32'hCAFE_0001 || mem_wstrb !== 4'hF) begin
                    n_fail++; $display("FAIL order_wdata: %h %h want cafe0001 f", mem_wdata, mem_wstrb);
                end
            end
            sb.push_back('{id: is_data, rdata: rd_vals[k]});
            step();
        end
        inst_sram_req = 0; data_sram_req = 0; mem_addr_ok = 0;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            mem_data_ok = 1; mem_rdata = rd_vals[k];
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (inst_sram_data_ok !== (e.id == ID_INST) || data_sram_data_ok !== (e.id == ID_DATA)
                || inst_sram_rdata !== e.rdata || data_sram_rdata !== e.rdata) begin
                n_fail++;
                $display("FAIL order_resp%0d: i_dok %b d_dok %b rdata %h/%h want id %b rdata %h",
                         k, inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata, e.id, e.rdata);
            end
            step();
        end
        mem_data_ok = 0;
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== 0) begin
            n_fail++; $display("FAIL order_drained: cnt %0d want 0", outstanding_cnt);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_empty_and_reset();
        do_reset();
        mem_data_ok = 1; mem_rdata = 32'h77;
        @(negedge clk);
        n_checks++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL empty_dok: i %b d %b want 0 0", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        mem_data_ok = 0;
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== 0) begin
            n_fail++; $display("FAIL empty_cnt: got %0d want 0", outstanding_cnt);
        end
        data_sram_req = 1; mem_addr_ok = 1;
        step();
        step();
        data_sram_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== 2) begin
            n_fail++; $display("FAIL midreset_pre: cnt %0d want 2", outstanding_cnt);
        end
        step();
        reset = 1;
        step();
        reset = 0;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (outstanding_cnt !== 0) begin
            n_fail++; $display("FAIL midreset_cnt: got %0d want 0", outstanding_cnt);
        end
        step();
        mem_data_ok = 1;
        @(negedge clk);
        n_checks++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL midreset_dok: i %b d %b want 0 0", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_tie();
        do_reset();
        inst_sram_req = 1; inst_sram_addr = 32'h1000;
        data_sram_req = 1; data_sram_addr = 32'h2000;
        mem_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            logic exp_data;
`ifdef ARB_ROUND_ROBIN_EN
            exp_data = (k % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            @(negedge clk);
            n_checks++;
            if (data_sram_addr_ok !== exp_data || inst_sram_addr_ok !== !exp_data
                || mem_addr !== (exp_data ? 32'h2000 : 32'h1000)) begin
                n_fail++;
                $display("FAIL tie_grant%0d: d_ok %b i_ok %b addr %h want data=%b", k,
                         data_sram_addr_ok, inst_sram_addr_ok, mem_addr, exp_data);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_lock();
        test_full();
        test_in_order();
        test_empty_and_reset();
        test_tie();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the maximum number of outstanding (addr accepted, data_ok pending) transactions; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have ports inst_sram_req/wr, input, 1 each, the instruction master's request and write flag.
REQ-005 The block SHALL have ports inst_sram_size (2), wstrb (4), addr (32) and wdata (32), all inputs, the instruction master's request payload.
REQ-006 The block SHALL have ports inst_sram_addr_ok/data_ok, output, 1 each, and inst_sram_rdata, output, 32, the instruction master's responses.
REQ-007 The block SHALL have ports data_sram_req/wr/size/wstrb/addr/wdata/addr_ok/data_ok/rdata, with the same directions and widths as the inst_sram_* set, for the data master.
REQ-008 The block SHALL have ports mem_req/wr/size/wstrb/addr/wdata, outputs, with widths 1/1/2/4/32/32, the shared downstream port.
REQ-009 The block SHALL have ports mem_addr_ok/data_ok, inputs, 1 each, and mem_rdata, input, 32, the downstream responses.
REQ-010 The block SHALL have port outstanding_cnt, output, log2(DEPTH)+1 bits, the number of accepted transactions awaiting data_ok.

Function
REQ-011 The block SHALL keep an owner register with states NONE, INST and DATA.
REQ-012 The selected master sel SHALL be owner when owner is not NONE; otherwise sel SHALL be the arbitration winner among the requesting masters (REQ-026).
REQ-013 mem_req SHALL equal sel's req AND NOT fifo_full; mem_wr/size/wstrb/addr/wdata SHALL be sel's payload, combinational with zero-cycle latency.
REQ-014 On mem_req=1 with mem_addr_ok=0, owner SHALL become sel, locking the grant so that a competing request cannot switch the port mid-handshake.
REQ-015 On mem_req=1 with mem_addr_ok=1, the block SHALL pulse addr_ok to sel only, push sel's ID into the ID FIFO, and set owner to NONE.
REQ-016 The non-selected master's addr_ok SHALL be 0; both addr_ok outputs SHALL be 0 when mem_req=0.
REQ-017 The ID FIFO SHALL be DEPTH entries deep, with read and write pointers wrapping modulo DEPTH and a count from 0 to DEPTH.
REQ-018 fifo_full SHALL be asserted when count equals DEPTH; a pop in the same cycle SHALL NOT unblock the push, so acceptance resumes the following cycle.
REQ-019 mem_data_ok=1 with count>0 SHALL pop the head entry and route the pulse to data_ok of the head ID in the same cycle; the other master's data_ok SHALL be 0.
REQ-020 mem_data_ok=1 with count=0 SHALL be ignored: no pop, no data_ok pulse, count unchanged.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 inst_sram_rdata and data_sram_rdata SHALL both equal mem_rdata.
REQ-023 Writes SHALL be tracked and answered with data_ok exactly like reads, preserving strict in-order response.
REQ-024 outstanding_cnt SHALL equal the FIFO count.

Reset
REQ-025 While reset=1 at a clock edge, owner SHALL become NONE, the pointers and count SHALL become 0 and last_gnt SHALL become INST; outputs are combinational from this state and the inputs, so after reset outstanding_cnt=0 and both addr_ok and data_ok outputs are 0 unless mem_req/mem_addr_ok/mem_data_ok are asserted. Reset mid-transaction SHALL discard all outstanding IDs; later mem_data_ok pulses SHALL then be ignored per REQ-020.

Configuration
REQ-026 Without ARB_ROUND_ROBIN_EN, when owner is NONE and both masters request, DATA SHALL always win.
REQ-027 With ARB_ROUND_ROBIN_EN defined, a last_gnt register SHALL update on every address handshake, and on a tie the master not equal to last_gnt SHALL win; the first tie after reset therefore goes to DATA.
REQ-028 With ARB_ROUND_ROBIN_EN defined, a single requester SHALL always win regardless of last_gnt.

Verification
REQ-029 Both reqs=1 at addr 0x1000 (inst) and 0x2000 (data) with mem_addr_ok=1 -> mem_addr=0x2000 first, data_sram_addr_ok pulse; inst is accepted the next cycle.
REQ-030 Inst req with mem_addr_ok held 0 for 3 cycles, data req raised in cycle 2 -> mem_addr stays at the inst address until addr_ok, with owner=INST locked.
REQ-031 DEPTH=4, 4 accepted reads with no data_ok -> outstanding_cnt=4 and mem_req=0; one mem_data_ok -> cnt=3 and mem_req returns the next cycle.
REQ-032 Issue inst, data, inst, then 3 mem_data_ok pulses with rdata 0xA, 0xB, 0xC -> inst, data and inst data_ok receive 0xA, 0xB and 0xC in order.
REQ-033 mem_data_ok with count=0 -> no data_ok pulse and cnt stays 0; reset asserted with cnt=2 -> cnt=0 on the next cycle.
REQ-034 With ARB_ROUND_ROBIN_EN, both masters requesting continuously -> grants alternate D, I, D, I.
